// File: rtl/map_loader.sv
// rtl/map_loader.sv - unpacks a two-tiles-per-byte stream into sequential map RAM writes
module map_loader #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 90,
    parameter int NUM_COLORS = 3
) (
    input  logic                              pixel_clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    input  logic [7:0]                        byte_in,
    input  logic                              byte_valid_in,
    output logic                              byte_ready_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr_out,
    output logic [3:0]                        wr_data_out,
    output logic                              wr_en_out,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              error_out
);
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int AW    = $clog2(TOTAL);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [4:0]    NC   = 5'(NUM_COLORS);

    typedef enum logic [2:0] {IDLE, LOAD, WR_LO, WR_HI, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hi_q, hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    data_q, data_d;
    logic          wr_en_q, wr_en_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          emit;
    logic [3:0]    nib;

    function automatic logic bad_code(input logic [3:0] code);
        return {1'b0, code} >= NC;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        emit    = 1'b0;
        nib     = 4'd0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (byte_valid_in && ready_q) begin
                    hi_d    = byte_in[7:4];
                    nib     = byte_in[3:0];
                    addr_d  = cnt_q[AW-1:0];
                    emit    = 1'b1;
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                // An odd-sized map ends on a low nibble; the high one is dropped.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    nib     = hi_q;
                    addr_d  = AW'(cnt_q + CW'(1));
                    emit    = 1'b1;
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                cnt_d   = cnt_q + CW'(2);
                state_d = (cnt_q + CW'(1) == LAST) ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (emit) begin
            data_d = bad_code(nib) ? 4'd0 : nib;
            if (bad_code(nib)) begin
                err_d = 1'b1;
            end
        end

        wr_en_d = emit;
        ready_d = (state_d == LOAD);
        busy_d  = (state_d == LOAD) || (state_d == WR_LO) || (state_d == WR_HI);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 4'd0;
            addr_q  <= '0;
            data_q  <= 4'd0;
            wr_en_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready_out = ready_q;
    assign wr_addr_out    = addr_q;
    assign wr_data_out    = data_q;
    assign wr_en_out      = wr_en_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign error_out      = err_q;
endmodule

// File: tb/tb_map_loader.sv
// tb/tb_map_loader.sv - scoreboard bench for map_loader (160x90 and 3x3 instances)
module tb_map_loader;
    localparam int WA = 160, HA = 90, TA = WA * HA, AWA = $clog2(TA);
    localparam int WB = 3, HB = 3, TB = WB * HB, AWB = $clog2(TB);
    localparam int NC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start_a = 1'b0, valid_a = 1'b0;
    logic [7:0]     byte_a = 8'd0;
    logic           ready_a, wr_a, busy_a, done_a, err_a;
    logic [AWA-1:0] addr_a;
    logic [3:0]     data_a;

    logic           start_b = 1'b0, valid_b = 1'b0;
    logic [7:0]     byte_b = 8'd0;
    logic           ready_b, wr_b, busy_b, done_b, err_b;
    logic [AWB-1:0] addr_b;
    logic [3:0]     data_b;

    map_loader #(.WIDTH(WA), .HEIGHT(HA), .NUM_COLORS(NC)) dut_a (
        .pixel_clk_in(clk), .rst_in(rst_n), .start_in(start_a), .byte_in(byte_a),
        .byte_valid_in(valid_a), .byte_ready_out(ready_a), .wr_addr_out(addr_a),
        .wr_data_out(data_a), .wr_en_out(wr_a), .busy_out(busy_a), .done_out(done_a),
        .error_out(err_a)
    );

    map_loader #(.WIDTH(WB), .HEIGHT(HB), .NUM_COLORS(NC)) dut_b (
        .pixel_clk_in(clk), .rst_in(rst_n), .start_in(start_b), .byte_in(byte_b),
        .byte_valid_in(valid_b), .byte_ready_out(ready_b), .wr_addr_out(addr_b),
        .wr_data_out(data_b), .wr_en_out(wr_b), .busy_out(busy_b), .done_out(done_b),
        .error_out(err_b)
    );

    typedef struct {int addr; int data;} wr_t;
    wr_t  exp_a[$], exp_b[$];
    wr_t  ea, eb;
    int   n_checks = 0, n_fail = 0;
    int   tiles[2];
    bit   err_exp[2];
    int   writes_a = 0, writes_b = 0, done_cnt_a = 0, done_cnt_b = 0, max_addr_b = 0;
    logic [3:0] ram_a[TA];
    logic [3:0] ref_a[TA];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: tile t of a load is nibble (t%2) of byte t/2; tiles past the map end vanish.
    task automatic model_byte(input int w, input logic [7:0] b);
        int total;
        int code;
        wr_t e;
        total = (w == 0) ? TA : TB;
        for (int k = 0; k < 2; k++) begin
            code = (k == 0) ? int'(b[3:0]) : int'(b[7:4]);
            if (tiles[w] < total) begin
                e.addr = tiles[w];
                e.data = (code < NC) ? code : 0;
                if (code >= NC) err_exp[w] = 1'b1;
                if (w == 0) begin
                    exp_a.push_back(e);
                    ref_a[tiles[w]] = 4'(e.data);
                end else begin
                    exp_b.push_back(e);
                end
                tiles[w]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (wr_a) begin
            writes_a++;
            ram_a[addr_a] = data_a;
            if (exp_a.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write_a: addr %0d data %0d, no write expected", addr_a, data_a);
            end else begin
                ea = exp_a.pop_front();
                check("wr_addr_a", int'(addr_a), ea.addr);
                check("wr_data_a", int'(data_a), ea.data);
            end
        end
        if (done_a) begin
            done_cnt_a++;
            check("busy_during_done_a", int'(busy_a), 0);
        end
        if (wr_b) begin
            writes_b++;
            if (int'(addr_b) > max_addr_b) max_addr_b = int'(addr_b);
            if (exp_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write_b: addr %0d data %0d, no write expected", addr_b, data_b);
            end else begin
                eb = exp_b.pop_front();
                check("wr_addr_b", int'(addr_b), eb.addr);
                check("wr_data_b", int'(data_b), eb.data);
            end
        end
        if (done_b) begin
            done_cnt_b++;
            check("busy_during_done_b", int'(busy_b), 0);
        end
    end

    task automatic start_load(input int w);
        if (w == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        tiles[w] = 0;
        err_exp[w] = 1'b0;
        if (w == 0) begin writes_a = 0; done_cnt_a = 0; end
        else begin writes_b = 0; done_cnt_b = 0; max_addr_b = 0; end
        check("busy_after_start", (w == 0) ? int'(busy_a) : int'(busy_b), 1);
    endtask

    task automatic send_byte(input int w, input logic [7:0] b, input int idle);
        int budget;
        budget = 200;
        for (int i = 0; i < idle; i++) @(negedge clk);
        if (w == 0) begin byte_a = b; valid_a = 1'b1; end
        else begin byte_b = b; valid_b = 1'b1; end
        while (((w == 0) ? ready_a : ready_b) !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: dut %0d ready never rose", w);
        end else begin
            model_byte(w, b);
        end
        @(negedge clk);
        if (w == 0) valid_a = 1'b0; else valid_b = 1'b0;
    endtask

    task automatic wait_done(input int w, output int lat);
        lat = 0;
        while (((w == 0) ? done_a : done_b) !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (((w == 0) ? done_a : done_b) !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: dut %0d done never pulsed, got 0 expected 1", w);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int mism;
        int first_bad;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready_a), 0);
        check("rst_wr_en", int'(wr_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_err", int'(err_a), 0);
        check("rst_addr", int'(addr_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two directed bytes, ready gap, then reset while a low-nibble write is on the port
        start_load(0);
        send_byte(0, 8'h21, 0);
        check("ready_gap_wr_lo", int'(ready_a), 0);
        @(negedge clk);
        check("ready_gap_wr_hi", int'(ready_a), 0);
        @(negedge clk);
        check("ready_back", int'(ready_a), 1);
        send_byte(0, 8'h10, 0);
        check("wr_lo_before_reset", int'(wr_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr_en", int'(wr_a), 0);
        check("abort_busy", int'(busy_a), 0);
        check("abort_ready", int'(ready_a), 0);
        check("abort_pending_writes", exp_a.size(), 1);
        exp_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Bad code first, then random bytes with backpressure and ignored mid-load starts
        start_load(0);
        send_byte(0, 8'h3F, 0);
        send_byte(0, 8'h21, 0);
        check("err_after_3f", int'(err_a), 1);
        for (int i = 2; i < TA / 2; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end
            b = 8'($urandom);
            send_byte(0, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
            if (i % 1000 == 0) check("err_sticky", int'(err_a), 1);
        end
        wait_done(0, lat);
        check("err_at_done", int'(err_a), int'(err_exp[0]));
        check("pending_after_bp", exp_a.size(), 0);
        check("writes_bp", writes_a, TA);
        mism = 0;
        first_bad = -1;
        for (int t = 0; t < TA; t++) begin
            if (ram_a[t] !== ref_a[t]) begin
                mism++;
                if (first_bad < 0) first_bad = t;
            end
        end
        check("image_mismatches", mism, 0);
        if (mism != 0) $display("  first differing tile %0d", first_bad);
        repeat (2) @(negedge clk);
        check("err_held_idle", int'(err_a), 1);

        // Full-rate load with in-range codes; start clears the error
        start_load(0);
        check("err_cleared_by_start", int'(err_a), 0);
        for (int i = 0; i < TA / 2; i++) begin
            b = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
            send_byte(0, b, 0);
        end
        check("busy_in_last_wr_lo", int'(busy_a), 1);
        wait_done(0, lat);
        check("done_latency_from_wr_lo", lat, 2);
        check("err_clean_load", int'(err_a), 0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("done_single_pulse", int'(done_a), 0);
        check("start_in_done_ignored", int'(busy_a), 0);
        @(negedge clk);
        check("idle_after_done", int'(busy_a), 0);
        check("idle_ready", int'(ready_a), 0);
        check("done_count_full", done_cnt_a, 1);
        check("writes_full", writes_a, TA);
        check("pending_full", exp_a.size(), 0);

        // Odd-sized 3x3 map: 5 bytes, last high nibble dropped
        start_load(1);
        send_byte(1, 8'h10, 0);
        send_byte(1, 8'h02, 1);
        send_byte(1, 8'h21, 0);
        send_byte(1, 8'h01, 2);
        send_byte(1, 8'hF2, 0);
        wait_done(1, lat);
        @(negedge clk);
        check("writes_odd", writes_b, TB);
        check("max_addr_odd", max_addr_b, TB - 1);
        check("pending_odd", exp_b.size(), 0);
        check("err_odd_dropped_nibble", int'(err_b), 0);
        check("done_count_odd", done_cnt_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
